// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_if                                                      |
// | Bus bundle between the core's fetch/data ports, the arbiter and the      |
// | shared single-ported memory.                                             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface mem_port_arbiter_if;
  // core status
  logic        halted;
  // instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // physical memory port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // status
  logic        busy;

  // Core/memory side: drives requests and read data, observes grants.
  modport master (
    output halted,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  halted,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Serialises instruction-fetch and data accesses onto one fixed-latency    |
// | single-ported memory. Data has priority; fetch wins after MAX_STREAK     |
// | consecutive data grants. Read data is routed back to the issuing port.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,   // 1..15
  parameter int MAX_STREAK = 4    // 1..15
) (
  input  logic               clk,
  input  logic               rst_b,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] c_LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] c_STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_lat_cnt;
  logic [3:0] r_streak;
  logic       r_owner_data;   // 0 = fetch owns the outstanding read, 1 = data

  logic w_idle;
  logic w_if_ok;
  logic w_fetch_ovr;
  logic w_d_gnt;
  logic w_if_gnt;
  logic w_rd_done;

  // Arbitration: grants only in IDLE and never while reset is asserted, so
  // every output reads 0 during reset regardless of the request inputs.
  assign w_idle      = rst_b && (r_state == S_IDLE);
  assign w_if_ok     = bus.if_req && !bus.halted;
  assign w_fetch_ovr = w_if_ok && (r_streak == c_STREAK_MAX);
  assign w_d_gnt     = w_idle && bus.d_req && !w_fetch_ovr;
  assign w_if_gnt    = w_idle && w_if_ok && (w_fetch_ovr || !bus.d_req);

  // Final RD_WAIT cycle: memory data is valid now.
  assign w_rd_done   = (r_state == S_RD_WAIT) && (r_lat_cnt == 4'd0);

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;

  assign bus.mem_en    = w_d_gnt || w_if_gnt;
  assign bus.mem_we    = w_d_gnt && bus.d_we;
  assign bus.mem_addr  = w_d_gnt  ? bus.d_addr  :
                         w_if_gnt ? bus.if_addr : 32'd0;
  assign bus.mem_wdata = (w_d_gnt && bus.d_we) ? bus.d_wdata : 32'd0;

  assign bus.if_rvalid = w_rd_done && !r_owner_data;
  assign bus.d_rvalid  = w_rd_done &&  r_owner_data;
  assign bus.if_rdata  = (w_rd_done && !r_owner_data) ? bus.mem_rdata : 32'd0;
  assign bus.d_rdata   = (w_rd_done &&  r_owner_data) ? bus.mem_rdata : 32'd0;

  assign bus.busy      = (r_state == S_RD_WAIT);

  // Transaction FSM with latency tracking, read ownership and streak count.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= 4'd0;
      r_streak     <= 4'd0;
      r_owner_data <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Writes finish in the grant cycle; only reads leave IDLE.
          if (w_d_gnt) begin
            if (!bus.d_we) begin
              r_state      <= S_RD_WAIT;
              r_lat_cnt    <= c_LAT_INIT;
              r_owner_data <= 1'b1;
            end
          end else if (w_if_gnt) begin
            r_state      <= S_RD_WAIT;
            r_lat_cnt    <= c_LAT_INIT;
            r_owner_data <= 1'b0;
          end

          // Streak counts data grants that made a pending fetch wait.
          if (w_if_gnt || !bus.if_req) begin
            r_streak <= 4'd0;
          end else if (w_d_gnt && (r_streak != c_STREAK_MAX)) begin
            r_streak <= r_streak + 4'd1;
          end
        end

        S_RD_WAIT: begin
          if (r_lat_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Directed self-checking bench, MEM_LAT=2, MAX_STREAK=4.                   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic clk;
  logic rst_b;
  int   checks;
  int   failures;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  logic [1:0]   w_gnts;     // {if_gnt, d_gnt}
  logic [134:0] w_all_out;
  assign w_gnts    = {bus.if_gnt, bus.d_gnt};
  assign w_all_out = {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
                      bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                      bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                      bus.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.halted    = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'd0;
    bus.d_wdata   = 32'd0;
    bus.mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.halted    = 1'($urandom_range(1, 0));
      bus.if_req    = 1'($urandom_range(1, 0));
      bus.if_addr   = $urandom();
      bus.d_req     = 1'($urandom_range(1, 0));
      bus.d_we      = 1'($urandom_range(1, 0));
      bus.d_addr    = $urandom();
      bus.d_wdata   = $urandom();
      bus.mem_rdata = $urandom();
      #1;
      checks++;
      if (w_all_out !== 135'd0) begin
        failures++;
        $display("FAIL reset_outputs iter=%0d actual=%h expected=0", i, w_all_out);
      end
      step();
    end
    clear_inputs();
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.mem_en, bus.busy} !== 2'b00) begin
        failures++;
        $display("FAIL post_reset_idle cyc=%0d actual={en,busy}=%b expected=00", i, {bus.mem_en, bus.busy});
      end
      step();
    end
  endtask

  task automatic test_fetch_read();
    // cycle 1: grant
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy} !== {4'b1010, 32'h40, 1'b0}) begin
      failures++;
      $display("FAIL fetch_grant actual=gnt%b/%b en%b we%b addr=%h busy%b expected=gnt1/0 en1 we0 addr=40 busy0",
               bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy);
    end
    step();
    // cycle 2: waiting, rdata must be masked
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'h12345678;
    #1;
    checks++;
    if ({bus.busy, bus.if_rvalid, bus.if_rdata, bus.mem_en} !== {2'b10, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL fetch_wait actual=busy%b rv%b rdata=%h en%b expected=busy1 rv0 rdata=0 en0",
               bus.busy, bus.if_rvalid, bus.if_rdata, bus.mem_en);
    end
    step();
    // cycle 3: data returns; requests present but no grant allowed
    bus.mem_rdata = 32'h8C010004;
    bus.if_req    = 1'b1;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h10;
    bus.d_wdata   = 32'h55;
    #1;
    checks++;
    if ({bus.busy, bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata} !== {2'b11, 32'h8C010004, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL fetch_rvalid actual=busy%b rv%b rdata=%h drv%b drdata=%h expected=busy1 rv1 rdata=8c010004 drv0 drdata=0",
               bus.busy, bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata);
    end
    checks++;
    if ({w_gnts, bus.mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL rvalid_cycle_no_grant actual={if,d,en}=%b expected=000", {w_gnts, bus.mem_en});
    end
    step();
    // cycle 4: back in IDLE, data write granted
    bus.if_req = 1'b0;
    #1;
    checks++;
    if ({bus.busy, w_gnts, bus.mem_we, bus.mem_wdata} !== {4'b0011, 32'h55}) begin
      failures++;
      $display("FAIL next_grant_after_read actual=busy%b gnts=%b we%b wdata=%h expected=busy0 gnts=01 we1 wdata=55",
               bus.busy, w_gnts, bus.mem_we, bus.mem_wdata);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_data_read();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h200;
    bus.d_wdata = 32'hFFFF0000;
    #1;
    checks++;
    if ({w_gnts, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b010, 32'h200, 32'd0}) begin
      failures++;
      $display("FAIL data_read_grant actual=gnts%b we%b addr=%h wdata=%h expected=gnts01 we0 addr=200 wdata=0",
               w_gnts, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    step();
    bus.d_req = 1'b0;
    step();
    bus.mem_rdata = 32'hA5A5_1234;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hA5A51234, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL data_read_return actual=drv%b drdata=%h irv%b irdata=%h expected=drv1 drdata=a5a51234 irv0 irdata=0",
               bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_collision();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'hDEADBEEF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    #1;
    checks++;
    if ({w_gnts, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b011, 32'h100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL collision_data_first actual=gnts%b we%b addr=%h wdata=%h expected=gnts01 we1 addr=100 wdata=deadbeef",
               w_gnts, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    step();
    bus.d_req = 1'b0;
    #1;
    checks++;
    if ({w_gnts, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b100, 32'h80, 32'd0}) begin
      failures++;
      $display("FAIL collision_fetch_next actual=gnts%b we%b addr=%h wdata=%h expected=gnts10 we0 addr=80 wdata=0",
               w_gnts, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    step();
    bus.if_req = 1'b0;
    step();
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_starvation();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.d_addr  = 32'h300 + 32'(4 * k);
      bus.d_wdata = 32'(k);
      #1;
      checks++;
      if (w_gnts !== 2'b01) begin
        failures++;
        $display("FAIL streak_data k=%0d actual=gnts%b expected=01", k, w_gnts);
      end
      step();
    end
    #1;
    checks++;
    if ({w_gnts, bus.mem_addr} !== {2'b10, 32'h500}) begin
      failures++;
      $display("FAIL streak_override actual=gnts%b addr=%h expected=gnts10 addr=500", w_gnts, bus.mem_addr);
    end
    step();
    // fetch read outstanding: two wait cycles with no grant
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (w_gnts !== 2'b00) begin
        failures++;
        $display("FAIL streak_rdwait k=%0d actual=gnts%b expected=00", k, w_gnts);
      end
      step();
    end
    // streak cleared by the fetch grant: data wins again
    #1;
    checks++;
    if (w_gnts !== 2'b01) begin
      failures++;
      $display("FAIL streak_cleared actual=gnts%b expected=01", w_gnts);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_halted();
    bus.halted  = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h700;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (w_gnts !== ((i % 3 == 0) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL halted_grants cyc=%0d actual=gnts%b expected=%b", i, w_gnts, ((i % 3 == 0) ? 2'b01 : 2'b00));
      end
      step();
    end
    // four data grants with fetch pending: override fires once unhalted
    bus.halted = 1'b0;
    #1;
    checks++;
    if ({w_gnts, bus.mem_addr} !== {2'b10, 32'h600}) begin
      failures++;
      $display("FAIL unhalt_fetch actual=gnts%b addr=%h expected=gnts10 addr=600", w_gnts, bus.mem_addr);
    end
    step();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_read();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    #1;
    checks++;
    if (w_gnts !== 2'b10) begin
      failures++;
      $display("FAIL midreset_grant actual=gnts%b expected=10", w_gnts);
    end
    step();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_before actual=%b expected=1", bus.busy);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if (w_all_out !== 135'd0) begin
      failures++;
      $display("FAIL midreset_abort actual=%h expected=0", w_all_out);
    end
    step();
    bus.mem_rdata = 32'hBAD0BAD0;
    rst_b = 1'b1;
    #1;
    checks++;
    if ({bus.if_rvalid, bus.if_rdata, bus.busy} !== {1'b0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_no_rvalid actual=rv%b rdata=%h busy%b expected=rv0 rdata=0 busy0",
               bus.if_rvalid, bus.if_rdata, bus.busy);
    end
    checks++;
    if ({w_gnts, bus.mem_addr} !== {2'b10, 32'h44}) begin
      failures++;
      $display("FAIL midreset_regrant actual=gnts%b addr=%h expected=gnts10 addr=44", w_gnts, bus.mem_addr);
    end
    step();
    bus.if_req = 1'b0;
    step();
    step();
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_b    = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch_read();
    test_data_read();
    test_collision();
    test_starvation();
    test_halted();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
